// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings (op_i field)
//   - controller state encoding
//   - iteration count and divide-by-zero quotient constant
//   - magnitude helper used when latching signed operands
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    localparam int          MDU_ITER_N  = 32;
    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    // Two's-complement magnitude when the operation is signed; raw value
    // otherwise. |0x80000000| stays 0x80000000, which reads correctly as an
    // unsigned magnitude.
    function automatic logic [31:0] mdu_mag(input logic [31:0] value,
                                            input logic        is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// ---------------------------------------------------------------------------
// mdu_iter_core
// One combinational iteration of either
//   - radix-2 shift-add multiply: acc = {partial_product_hi, multiplier_bits}
//   - restoring divide:           acc = {partial_remainder, dividend/quotient}
// Ports:
//   is_div   in   1   select divide step (1) or multiply step (0)
//   acc_in   in  64   accumulator before the step
//   operand  in  32   multiplicand (multiply) or divisor (divide) magnitude
//   acc_out  out 64   accumulator after the step
// ---------------------------------------------------------------------------
module mdu_iter_core (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [31:0] addend;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        fits;
    logic [31:0] new_rem;

    always_comb begin
        // Multiply: add multiplicand into the top half when the current
        // multiplier LSB is set, then shift the whole 65-bit value right.
        addend = acc_in[0] ? operand : 32'd0;
        sum    = {1'b0, acc_in[63:32]} + {1'b0, addend};

        // Divide: shift the next dividend bit into a 33-bit partial
        // remainder and subtract the divisor if it fits. When it fits the
        // true difference is below 2^32, so 32-bit modular arithmetic is exact.
        rem_sh  = acc_in[63:31];
        fits    = (rem_sh >= {1'b0, operand});
        diff    = rem_sh[31:0] - operand;
        new_rem = fits ? diff : rem_sh[31:0];

        if (is_div) begin
            acc_out = {new_rem, acc_in[30:0], fits};
        end else begin
            acc_out = {sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit for the EX stage. Produces the HI/LO pair
// for MULT/MULTU/DIV/DIVU and supports mthi/mtlo writes while idle.
// Operation latency: busy_o for 33 cycles after the start edge, done_o
// pulses in the following cycle as HI/LO take their new values.
//
// Build option:
//   MDU_FAST_MULT_EN  when defined, MULT/MULTU bypass the iterative loop and
//                     use a single-cycle 64-bit multiply (busy 1 cycle).
//
// Ports:
//   clk_i     in   1  clock, rising edge
//   rst_i     in   1  synchronous active-high reset
//   start_i   in   1  launch operation (accepted only in IDLE)
//   op_i      in   2  0=MULT 1=MULTU 2=DIV 3=DIVU
//   src1_i    in  32  multiplicand / dividend
//   src2_i    in  32  multiplier / divisor
//   abort_i   in   1  cancel in-flight operation
//   hi_we_i   in   1  mthi write enable (IDLE only)
//   lo_we_i   in   1  mtlo write enable (IDLE only)
//   wdata_i   in  32  mthi/mtlo data
//   busy_o    out  1  state != IDLE
//   done_o    out  1  one-cycle pulse after HI/LO update by an operation
//   hi_o      out 32  HI register
//   lo_o      out 32  LO register
//
// Handshake: start_i is a single-cycle request sampled only while busy_o=0
// and abort_i=0; once accepted nothing is sampled from src/op until the unit
// returns to IDLE. done_o is a pulse, not a valid/ready pair: the consumer
// must take HI/LO from that cycle onward and there is no backpressure.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER_N = MDU_ITER_N
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              abort_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(ITER_N);

    // Controller state is kept as a plain named signal so checkers can bind
    // to it directly.
    mdu_state_e        state;
    mdu_op_e           op_r;
    logic [31:0]       operand;   // multiplicand or divisor magnitude
    logic [63:0]       acc;       // working accumulator
    logic [CNT_W-1:0]  count;
    logic              neg_res;   // product / quotient must be negated
    logic              neg_rem;   // remainder takes dividend sign
    logic              div_zero;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic              done;

    logic              op_is_div;
    logic              start_div;
    logic              start_signed;
    logic [31:0]       mag1;
    logic [31:0]       mag2;
    logic [63:0]       acc_step;
    logic [63:0]       prod;
    logic [63:0]       prod_fix;
    logic [31:0]       quo_fix;
    logic [31:0]       rem_fix;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    assign op_is_div    = (op_r == MDU_DIV) || (op_r == MDU_DIVU);
    assign start_div    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign start_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign mag1         = mdu_mag(src1_i, start_signed);
    assign mag2         = mdu_mag(src2_i, start_signed);

    mdu_iter_core u_core (
        .is_div  (op_is_div),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (acc_step)
    );

    // Sign correction and result selection, consumed at the FIN edge.
    always_comb begin
        prod = acc;
`ifdef MDU_FAST_MULT_EN
        // Fast path: the multiplier magnitude is still parked in acc[31:0].
        if (!op_is_div) begin
            prod = 64'(operand) * 64'(acc[31:0]);
        end
`endif
        prod_fix = neg_res ? (~prod + 64'd1) : prod;
        quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (op_is_div) begin
            // Divide by zero leaves the remainder equal to the dividend
            // naturally; only the quotient needs forcing.
            res_hi = rem_fix;
            res_lo = div_zero ? MDU_DIV0_LO : quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_r     <= MDU_MULT;
            operand  <= '0;
            acc      <= '0;
            count    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we_i) hi <= wdata_i;
                    if (lo_we_i) lo <= wdata_i;
                    if (start_i && !abort_i) begin
                        op_r     <= mdu_op_e'(op_i);
                        operand  <= start_div ? mag2 : mag1;
                        acc      <= {32'd0, start_div ? mag1 : mag2};
                        neg_res  <= start_signed && (src1_i[31] ^ src2_i[31]);
                        neg_rem  <= start_signed && src1_i[31];
                        div_zero <= (src2_i == 32'd0);
                        count    <= '0;
`ifdef MDU_FAST_MULT_EN
                        state    <= start_div ? CALC : FIN;
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_step;
                        count <= count + 1'b1;
                        if (count == CNT_W'(ITER_N - 1)) state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!abort_i) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = done;
    assign hi_o   = hi;
    assign lo_o   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed and random operations are
// issued by a driver that pushes the reference result into exp_q; a monitor
// pops and compares whenever done_o is seen. The driver also checks busy/done
// timing; separate sequences cover abort, mthi/mtlo and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        abort;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] shadow;   // expected {HI,LO} held by the unit right now

    mult_div_unit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src1_i  (src1),
        .src2_i  (src2),
        .abort_i (abort),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference model from the arithmetic definition of each operation.
    function automatic logic [63:0] ref_model(input logic [1:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic   sgn;
        logic [63:0] res;
        sgn = (o == 2'd0) || (o == 2'd2);
        sa  = sgn ? longint'($signed(a)) : longint'(a);
        sb  = sgn ? longint'($signed(b)) : longint'(b);
        if (o < 2'd2) begin
            p   = sa * sb;
            res = p;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        start = 1'b0;
        abort = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Issue one operation and check busy length / done position. When wr_hi
    // is set an mthi is applied in the same cycle as the start.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wr_hi, input logic [31:0] wd);
        logic [63:0] e;
        int lat, busy_cnt, done_k;
        e   = ref_model(o, a, b);
        lat = 33;
`ifdef MDU_FAST_MULT_EN
        if (o < 2'd2) lat = 1;
`endif
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        hi_we = wr_hi; wdata = wd;
        exp_q.push_back(e);
        busy_cnt = 0;
        done_k   = 0;
        for (int k = 1; k <= lat + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (wr_hi) check("mthi_with_start", {32'd0, hi}, {32'd0, wd});
                idle_inputs();
                // Operands must already be latched.
                src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        check("done_cycle", 64'(done_k), 64'(lat + 1));
        shadow = e;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        op = 2'd0; src1 = '0; src2 = '0; wdata = '0;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        shadow = 64'd0;

        // Directed operations
        issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
        issue(2'd3, 32'd100, 32'd7, 1'b0, 32'd0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
        issue(2'd3, 32'd100, 32'd0, 1'b0, 32'd0);
        issue(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b0, 32'd0);
        issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b0, 32'd0);
        end

        // Abort: second start and mthi during busy are ignored; abort at k=10.
        @(negedge clk);
        start = 1'b1; op = 2'd0; src1 = 32'd5; src2 = 32'd9;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k == 5) begin start = 1'b1; op = 2'd3; src1 = 32'd50; src2 = 32'd3; end
            if (k == 6) begin hi_we = 1'b1; wdata = 32'h1234; end
            if (k == 10) abort = 1'b1;
            if (k == 11) begin
                check("abort_busy_low", {63'd0, busy}, 64'd0);
                check("abort_hilo_kept", {hi, lo}, shadow);
            end
        end
        wait_cycles(40);
        check("abort_no_late_write", {hi, lo}, shadow);

        // mthi / mtlo in IDLE
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        idle_inputs();
        check("mthi_idle", {32'd0, hi}, 64'h1234);
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        idle_inputs();
        check("mtlo_idle", {32'd0, lo}, 64'hCAFE_F00D);

        // abort and start together in IDLE: start rejected
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 2'd1; src1 = 32'd3; src2 = 32'd4;
        @(negedge clk);
        idle_inputs();
        check("abort_beats_start", {63'd0, busy}, 64'd0);
        wait_cycles(36);
        check("abort_start_hilo", {hi, lo}, {32'h1234, 32'hCAFE_F00D});

        // mthi in the same cycle as start: write lands, result then overwrites
        issue(2'd3, 32'd100, 32'd7, 1'b1, 32'h5555_AAAA);

        // Reset mid-DIV
        @(negedge clk);
        start = 1'b1; op = 2'd2; src1 = 32'hFFFF_0000; src2 = 32'd3;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k == 20) rst = 1'b1;
            if (k == 21) begin
                rst = 1'b0;
                check("midop_reset_busy", {63'd0, busy}, 64'd0);
                check("midop_reset_done", {63'd0, done}, 64'd0);
                check("midop_reset_hilo", {hi, lo}, 64'd0);
            end
        end
        wait_cycles(20);
        check("post_reset_idle", {63'd0, busy}, 64'd0);

        // A normal operation after reset
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);

        wait_cycles(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the EX stage of the MIPS datapath.
- Takes the same src1/src2 operands that feed the ALU and produces the HI/LO register pair.
- The EX-stage result mux reads HI/LO for mfhi/mflo.
- Multicycle: asserts busy_o so the hazard/stall logic freezes the pipeline until the result is written.

Parameters:
DATA_W, 32, operand width; only 32 is supported, and the parameter is used only for port sizing.
ITER_N, 32, number of iteration cycles; must equal DATA_W.

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  launch operation; sampled only in IDLE
op_i  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
src1_i  input  32  rs operand (multiplicand / dividend)
src2_i  input  32  rt operand (multiplier / divisor)
abort_i  input  1  pipeline flush; cancels in-flight operation
hi_we_i  input  1  mthi write enable
lo_we_i  input  1  mtlo write enable
wdata_i  input  32  mthi/mtlo write data
busy_o  output  1  operation in flight (state != IDLE)
done_o  output  1  one-cycle pulse: HI/LO just updated by an operation
hi_o  output  32  HI register
lo_o  output  32  LO register

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE, hi_o=0, lo_o=0, done_o=0, busy_o=0, iteration count=0. Reset overrides everything, including an operation in progress.
- States and transitions:
  - IDLE -> CALC on start_i.
  - CALC -> FIN after ITER_N cycles.
  - FIN -> IDLE unconditionally.
  - Any state -> IDLE on abort_i.
- IDLE + start_i at edge N: latch op_i; latch |src1_i| and |src2_i| (signed ops) or raw values (unsigned ops); latch the result sign flags; clear the counter.
- CALC:
  - Multiply is radix-2 shift-add on a 64-bit accumulator.
  - Divide is restoring, one quotient bit per cycle, with a 33-bit partial remainder.
  - The counter increments every cycle; CALC exits when count==ITER_N-1.
- FIN:
  - Apply sign fix: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
  - Write HI/LO at the closing edge.
  - done_o=1 for exactly the following cycle.
- Timing:
  - busy_o high in cycles N+1..N+33 (33 cycles).
  - done_o high in cycle N+34.
  - HI/LO hold the new values from cycle N+34 onward.
- Results:
  - MULT/MULTU: {HI,LO} = full 64-bit product.
  - DIV/DIVU: LO=quotient (truncated toward zero), HI=remainder.
  - Divide by zero: no exception; HI=dividend (src1 as latched, original sign), LO=0xFFFFFFFF. Still takes the full 34-cycle latency.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- start_i while busy_o=1: ignored; the operands are not relatched.
- abort_i:
  - While busy: returns to IDLE at the next edge; HI/LO unchanged; no done_o.
  - In IDLE: no effect on state.
  - abort_i and start_i in the same cycle: abort wins; the start is not accepted.
- mthi/mtlo:
  - Accepted only in IDLE; HI or LO written at the edge from wdata_i.
  - Ignored while busy_o=1.
  - Same cycle as start_i: the write is applied and the start is also accepted; the later result overwrites it.
- hi_o/lo_o are direct register outputs with no combinational path from inputs.

Optional Feature:
MDU_FAST_MULT_EN
- Defined:
  - MULT/MULTU skip CALC: IDLE -> FIN using a single-cycle 64-bit multiply on the latched operands.
  - busy_o high for 1 cycle (N+1); done_o in cycle N+2.
  - Divide timing unchanged.
- Undefined: iterative multiply exactly as specified above.

Decomposition:
- Package mdu_pkg:
  - op encodings MDU_MULT/MULTU/DIV/DIVU.
  - state enum IDLE/CALC/FIN.
  - ITER_N constant.
  - divide-by-zero LO constant 0xFFFFFFFF.
- Sub-module mdu_iter_core: one combinational step of shift-add multiply or restoring divide (accumulator in, accumulator out, op select). The top level keeps the FSM, counter, sign fix and HI/LO registers.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; busy_o cycles N+1..N+33; done_o pulse exactly at N+34.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 100/7 -> lo_o=14, hi_o=2; DIV 0x80000000/-1 -> lo_o=0x80000000, hi_o=0.
- DIVU 100/0 -> hi_o=0x00000064, lo_o=0xFFFFFFFF after 34 cycles; no X on outputs.
- Abort path: start MULT at N; start_i pulsed again at N+5 (ignored); abort_i at N+10 -> busy_o=0 at N+11, hi_o/lo_o keep prior values, no done_o. mthi 0x1234 during busy is ignored; mthi 0x1234 in IDLE -> hi_o=0x1234.
- Reset: rst_i high at N+20 mid-DIV -> next cycle state IDLE, hi_o=lo_o=0, busy_o=0, done_o=0.
